pipe_hazard_ctrl: RTL and testbench

- Central hazard and pipeline-control block for the 5-stage IF/ID/EX/DM/WB core.
- Tracks in-flight destination registers in a shadow pipeline and drives the ID-stage stall and bubble signals.
- Flushes younger stages when a branch or jump redirects from DM, and produces registered forwarding selects for the EX operands.
- Runs the halt-drain state machine that raises `hlt` only after all older instructions have retired.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/haz_match.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes,
// halt FSM states and the shadow-pipeline entry.
package pipe_pkg;

    localparam int MAX_REG_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_EXDM = 2'd1,
        FWD_DMWB = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [MAX_REG_AW-1:0] wr_addr;
        logic                  is_load;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

endpackage

// File: rtl/haz_match.sv
// Compares one ID source operand against one in-flight shadow entry.
// Register 0 is treated as hazard-free when ZERO_REG_EN is set.
module haz_match
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              src_used,
    input  logic [REG_AW-1:0] src_addr,
    input  shadow_t           entry,
    output logic              match
);

    logic zero_src;
    logic unused_load;

    assign zero_src    = (ZERO_REG_EN != 0) && (src_addr == '0);
    assign unused_load = entry.is_load;

    assign match = src_used && entry.valid && entry.wr_en && !zero_src
                   && (entry.wr_addr == MAX_REG_AW'(src_addr));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush generation, EX forwarding selects and halt drain for
// the 5-stage core. Forwarding is built only when HAZ_FWD_EN is defined.
//
// state     | meaning
// ST_RUN    | normal issue
// ST_DRAIN  | halt left ID, older instructions retiring, fetch held
// ST_HALTED | hlt raised, terminal until reset
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int DRAIN_CYC   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src0_addr,
    input  logic [REG_AW-1:0] id_src1_addr,
    input  logic              id_src0_used,
    input  logic              id_src1_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              id_is_halt,
    input  logic              dm_redirect,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              flush_ex_dm,
    output logic [1:0]        fwd_sel0,
    output logic [1:0]        fwd_sel1,
    output logic              hlt
);

    localparam int CNT_W = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_LATE = CNT_W'(DRAIN_CYC - 1);

    shadow_t     ex_q, dm_q, id_entry;
    halt_state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic m_ex0, m_ex1, m_dm0, m_dm1;
    logic haz;
    logic unused_bits;

    haz_match #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_m_ex0 (
        .src_used(id_src0_used), .src_addr(id_src0_addr), .entry(ex_q), .match(m_ex0));
    haz_match #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_m_ex1 (
        .src_used(id_src1_used), .src_addr(id_src1_addr), .entry(ex_q), .match(m_ex1));
    haz_match #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_m_dm0 (
        .src_used(id_src0_used), .src_addr(id_src0_addr), .entry(dm_q), .match(m_dm0));
    haz_match #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_m_dm1 (
        .src_used(id_src1_used), .src_addr(id_src1_addr), .entry(dm_q), .match(m_dm1));

`ifdef HAZ_FWD_EN
    assign haz         = id_valid && (m_ex0 || m_ex1) && ex_q.is_load;
    assign unused_bits = dm_q.is_load;
`else
    // Without bypass paths every in-flight producer must reach WB first.
    assign haz         = id_valid && (m_ex0 || m_ex1 || m_dm0 || m_dm1);
    assign unused_bits = ^{ex_q.is_load, dm_q.is_load};
`endif

    assign stall_if_id  = (state_q == ST_HALTED)
                          || (!dm_redirect && (haz || state_q == ST_DRAIN));
    assign bubble_id_ex = dm_redirect || haz;
    assign flush_if_id  = dm_redirect || (state_q != ST_RUN);
    assign flush_ex_dm  = dm_redirect;

    assign id_entry = '{valid:   id_valid,
                        wr_en:   id_wr_en,
                        wr_addr: MAX_REG_AW'(id_wr_addr),
                        is_load: id_is_load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= SHADOW_EMPTY;
            dm_q <= SHADOW_EMPTY;
        end else begin
            ex_q <= bubble_id_ex ? SHADOW_EMPTY : id_entry;
            dm_q <= dm_redirect ? SHADOW_EMPTY : ex_q;
        end
    end

`ifdef HAZ_FWD_EN
    fwd_sel_t fwd0_d, fwd1_d, fwd0_q, fwd1_q;

    always_comb begin
        fwd0_d = FWD_RF;
        fwd1_d = FWD_RF;
        if (id_valid) begin
            if (m_ex0)      fwd0_d = FWD_EXDM;
            else if (m_dm0) fwd0_d = FWD_DMWB;
            if (m_ex1)      fwd1_d = FWD_EXDM;
            else if (m_dm1) fwd1_d = FWD_DMWB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd0_q <= FWD_RF;
            fwd1_q <= FWD_RF;
        end else begin
            fwd0_q <= bubble_id_ex ? FWD_RF : fwd0_d;
            fwd1_q <= bubble_id_ex ? FWD_RF : fwd1_d;
        end
    end

    assign fwd_sel0 = fwd0_q;
    assign fwd_sel1 = fwd1_q;
`else
    assign fwd_sel0 = FWD_RF;
    assign fwd_sel1 = FWD_RF;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            hlt     <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (id_valid && id_is_halt && !haz && !dm_redirect) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // An early redirect comes from an instruction older than the halt.
                    if (dm_redirect && (cnt_q == CNT_LOAD || cnt_q == CNT_LATE)) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_HALTED;
                        cnt_q   <= '0;
                        hlt     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HALTED: hlt <= 1'b1;
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                    hlt     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario tests plus a randomized run against an instruction-history model
// of the hazard controller; honours HAZ_FWD_EN the same way as the design.
module tb_pipe_hazard_ctrl;

    localparam int DC = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_src0_used, id_src1_used, id_wr_en, id_is_load, id_is_halt;
    logic [3:0] id_src0_addr, id_src1_addr, id_wr_addr;
    logic       dm_redirect;
    logic       stall_if_id, bubble_id_ex, flush_if_id, flush_ex_dm, hlt;
    logic [1:0] fwd_sel0, fwd_sel1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit v;
        bit wr;
        bit ld;
        int addr;
    } inst_t;

    pipe_hazard_ctrl #(.REG_AW(4), .ZERO_REG_EN(1), .DRAIN_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid),
        .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
        .id_src0_used(id_src0_used), .id_src1_used(id_src1_used),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_is_load(id_is_load), .id_is_halt(id_is_halt),
        .dm_redirect(dm_redirect),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .flush_ex_dm(flush_ex_dm),
        .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .hlt(hlt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        id_valid = 0; id_src0_used = 0; id_src1_used = 0; id_wr_en = 0;
        id_is_load = 0; id_is_halt = 0; dm_redirect = 0;
        id_src0_addr = '0; id_src1_addr = '0; id_wr_addr = '0;
    endtask

    task automatic drive_op(input int s0, input bit u0, input int s1, input bit u1,
                            input bit we, input int wa, input bit ld, input bit hl);
        id_valid = 1; id_src0_addr = 4'(s0); id_src0_used = u0;
        id_src1_addr = 4'(s1); id_src1_used = u1; id_wr_en = we;
        id_wr_addr = 4'(wa); id_is_load = ld; id_is_halt = hl;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    function automatic bit writes(inst_t p, int a, bit used);
        return used && p.v && p.wr && (p.addr == a) && (a != 0);
    endfunction

    task automatic test_reset();
        do_reset();
        drive_op(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive_idle();
        tick();
        n_vec++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL rst_pre_drain got=%0b exp=1", stall_if_id); end
        rst_n = 0;
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%0b exp=0", stall_if_id); end
        n_vec++; if (flush_if_id !== 1'b0) begin n_bad++; $display("FAIL rst_flush_if got=%0b exp=0", flush_if_id); end
        n_vec++; if ({bubble_id_ex, flush_ex_dm} !== 2'b00) begin n_bad++; $display("FAIL rst_bub_fex got=%b exp=00", {bubble_id_ex, flush_ex_dm}); end
        n_vec++; if ({fwd_sel0, fwd_sel1} !== 4'b0) begin n_bad++; $display("FAIL rst_fwd got=%b exp=0000", {fwd_sel0, fwd_sel1}); end
        n_vec++; if (hlt !== 1'b0) begin n_bad++; $display("FAIL rst_hlt got=%0b exp=0", hlt); end
    endtask

    task automatic test_fwd_exdm();
        do_reset();
        drive_op(2, 1, 3, 1, 1, 1, 0, 0);
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL exdm_prod_stall got=%0b exp=0", stall_if_id); end
        tick();
        drive_op(1, 1, 5, 1, 1, 4, 0, 0);
        #1;
`ifdef HAZ_FWD_EN
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL exdm_stall got=%0b exp=0", stall_if_id); end
        tick();
        drive_idle();
        n_vec++; if (fwd_sel0 !== 2'd1) begin n_bad++; $display("FAIL exdm_fwd0 got=%0d exp=1", fwd_sel0); end
        n_vec++; if (fwd_sel1 !== 2'd0) begin n_bad++; $display("FAIL exdm_fwd1 got=%0d exp=0", fwd_sel1); end
`else
        n_vec++; if ({stall_if_id, bubble_id_ex} !== 2'b11) begin n_bad++; $display("FAIL d1_stall_c1 got=%b exp=11", {stall_if_id, bubble_id_ex}); end
        tick();
        #1;
        n_vec++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL d1_stall_c2 got=%0b exp=1", stall_if_id); end
        tick();
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL d1_stall_c3 got=%0b exp=0", stall_if_id); end
        tick();
        drive_idle();
        n_vec++; if (fwd_sel0 !== 2'd0) begin n_bad++; $display("FAIL nofwd_sel0 got=%0d exp=0", fwd_sel0); end
`endif
    endtask

    task automatic test_fwd_dmwb();
        do_reset();
        drive_op(2, 1, 3, 1, 1, 1, 0, 0);
        tick();
        drive_op(8, 1, 9, 1, 1, 10, 0, 0);
        tick();
        drive_op(1, 1, 1, 1, 1, 11, 0, 0);
        #1;
`ifdef HAZ_FWD_EN
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL dmwb_stall got=%0b exp=0", stall_if_id); end
        tick();
        drive_idle();
        n_vec++; if ({fwd_sel0, fwd_sel1} !== 4'b1010) begin n_bad++; $display("FAIL dmwb_fwd got=%b exp=1010", {fwd_sel0, fwd_sel1}); end
`else
        n_vec++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL d2_stall_c1 got=%0b exp=1", stall_if_id); end
        tick();
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL d2_stall_c2 got=%0b exp=0", stall_if_id); end
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        drive_op(2, 1, 0, 0, 1, 6, 1, 0);
        tick();
        drive_op(6, 1, 6, 1, 1, 7, 0, 0);
        #1;
        n_vec++; if ({stall_if_id, bubble_id_ex} !== 2'b11) begin n_bad++; $display("FAIL lu_stall got=%b exp=11", {stall_if_id, bubble_id_ex}); end
        tick();
        #1;
`ifdef HAZ_FWD_EN
        n_vec++; if (fwd_sel0 !== 2'd0) begin n_bad++; $display("FAIL lu_bubble_fwd got=%0d exp=0", fwd_sel0); end
        n_vec++; if ({stall_if_id, bubble_id_ex} !== 2'b00) begin n_bad++; $display("FAIL lu_release got=%b exp=00", {stall_if_id, bubble_id_ex}); end
        tick();
        drive_idle();
        n_vec++; if ({fwd_sel0, fwd_sel1} !== 4'b1010) begin n_bad++; $display("FAIL lu_fwd got=%b exp=1010", {fwd_sel0, fwd_sel1}); end
`else
        n_vec++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL lu_nofwd_c2 got=%0b exp=1", stall_if_id); end
        tick();
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL lu_nofwd_c3 got=%0b exp=0", stall_if_id); end
`endif
    endtask

    task automatic test_redirect();
        do_reset();
        drive_op(2, 1, 0, 0, 1, 6, 1, 0);
        tick();
        drive_op(6, 1, 6, 1, 1, 7, 0, 0);
        dm_redirect = 1;
        #1;
        n_vec++; if ({flush_if_id, bubble_id_ex, flush_ex_dm} !== 3'b111) begin n_bad++; $display("FAIL rd_flush got=%b exp=111", {flush_if_id, bubble_id_ex, flush_ex_dm}); end
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL rd_stall got=%0b exp=0", stall_if_id); end
        tick();
        dm_redirect = 0;
        #1;
        n_vec++; if ({stall_if_id, bubble_id_ex, flush_ex_dm} !== 3'b000) begin n_bad++; $display("FAIL rd_empty got=%b exp=000", {stall_if_id, bubble_id_ex, flush_ex_dm}); end
        n_vec++; if (fwd_sel0 !== 2'd0) begin n_bad++; $display("FAIL rd_fwd_a got=%0d exp=0", fwd_sel0); end
        tick();
        drive_idle();
        n_vec++; if ({fwd_sel0, fwd_sel1} !== 4'b0) begin n_bad++; $display("FAIL rd_fwd_b got=%b exp=0000", {fwd_sel0, fwd_sel1}); end
    endtask

    task automatic test_halt();
        do_reset();
        drive_op(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL halt_issue_stall got=%0b exp=0", stall_if_id); end
        tick();
        drive_idle();
        for (int k = 1; k <= DC + 3; k++) begin
            #1;
            n_vec++; if (hlt !== (k > DC)) begin n_bad++; $display("FAIL halt_hlt_k%0d got=%0b exp=%0b", k, hlt, (k > DC)); end
            n_vec++; if ({stall_if_id, flush_if_id} !== 2'b11) begin n_bad++; $display("FAIL halt_hold_k%0d got=%b exp=11", k, {stall_if_id, flush_if_id}); end
            tick();
        end
        dm_redirect = 1;
        #1;
        n_vec++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL halted_rd_stall got=%0b exp=1", stall_if_id); end
        dm_redirect = 0;
    endtask

    task automatic test_halt_squash();
        do_reset();
        drive_op(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive_idle();
        dm_redirect = 1;
        #1;
        n_vec++; if ({stall_if_id, flush_if_id} !== 2'b01) begin n_bad++; $display("FAIL sq_rd got=%b exp=01", {stall_if_id, flush_if_id}); end
        tick();
        dm_redirect = 0;
        #1;
        n_vec++; if ({stall_if_id, flush_if_id} !== 2'b00) begin n_bad++; $display("FAIL sq_run got=%b exp=00", {stall_if_id, flush_if_id}); end
        for (int k = 2; k <= DC + 4; k++) begin
            n_vec++; if (hlt !== 1'b0) begin n_bad++; $display("FAIL sq_hlt_k%0d got=%0b exp=0", k, hlt); end
            tick();
        end
    endtask

    task automatic test_r0();
        do_reset();
        drive_op(2, 1, 3, 1, 1, 0, 1, 0);
        tick();
        drive_op(0, 1, 0, 1, 1, 5, 0, 0);
        #1;
        n_vec++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL r0_stall got=%0b exp=0", stall_if_id); end
        tick();
        drive_idle();
        n_vec++; if ({fwd_sel0, fwd_sel1} !== 4'b0) begin n_bad++; $display("FAIL r0_fwd got=%b exp=0000", {fwd_sel0, fwd_sel1}); end
    endtask

    task automatic test_random(input int n_cyc);
        inst_t hist[$];
        inst_t nop, cur, d1, d2;
        int halt_at, cyc, since, e_fwd0, e_fwd1;
        bit e_hlt, haz, draining, halted, redir, w10, w11, w20, w21;
        bit e_stall, e_bub, e_fif, e_fex;
        nop = '{v: 0, wr: 0, ld: 0, addr: 0};
        do_reset();
        hist = '{nop, nop};
        halt_at = -1; cyc = 0; e_fwd0 = 0; e_fwd1 = 0; e_hlt = 0;
        for (int i = 0; i < n_cyc; i++) begin
            n_vec++; if (fwd_sel0 !== 2'(e_fwd0)) begin n_bad++; $display("FAIL rnd_fwd0 i=%0d got=%0d exp=%0d", i, fwd_sel0, e_fwd0); end
            n_vec++; if (fwd_sel1 !== 2'(e_fwd1)) begin n_bad++; $display("FAIL rnd_fwd1 i=%0d got=%0d exp=%0d", i, fwd_sel1, e_fwd1); end
            n_vec++; if (hlt !== e_hlt) begin n_bad++; $display("FAIL rnd_hlt i=%0d got=%0b exp=%0b", i, hlt, e_hlt); end
            id_valid     = ($urandom_range(0, 4) != 0);
            id_src0_addr = 4'($urandom_range(0, 3));
            id_src1_addr = 4'($urandom_range(0, 3));
            id_src0_used = 1'($urandom_range(0, 1));
            id_src1_used = 1'($urandom_range(0, 1));
            id_wr_en     = 1'($urandom_range(0, 1));
            id_wr_addr   = 4'($urandom_range(0, 3));
            id_is_load   = ($urandom_range(0, 2) == 0);
            id_is_halt   = ($urandom_range(0, 39) == 0);
            dm_redirect  = ($urandom_range(0, 9) == 0);
            #1;
            cur = '{v: id_valid, wr: id_wr_en, ld: id_is_load, addr: int'(id_wr_addr)};
            d1 = hist[hist.size() - 1];
            d2 = hist[hist.size() - 2];
            w10 = writes(d1, int'(id_src0_addr), id_src0_used);
            w11 = writes(d1, int'(id_src1_addr), id_src1_used);
            w20 = writes(d2, int'(id_src0_addr), id_src0_used);
            w21 = writes(d2, int'(id_src1_addr), id_src1_used);
`ifdef HAZ_FWD_EN
            haz = id_valid && (w10 || w11) && d1.ld;
`else
            haz = id_valid && (w10 || w11 || w20 || w21);
`endif
            since    = cyc - halt_at;
            draining = (halt_at >= 0) && (since >= 1) && (since <= DC);
            halted   = (halt_at >= 0) && (since > DC);
            redir    = dm_redirect;
            e_stall  = halted || (!redir && (haz || draining));
            e_bub    = redir || haz;
            e_fif    = redir || (halt_at >= 0);
            e_fex    = redir;
            n_vec++; if (stall_if_id !== e_stall) begin n_bad++; $display("FAIL rnd_stall i=%0d got=%0b exp=%0b", i, stall_if_id, e_stall); end
            n_vec++; if (bubble_id_ex !== e_bub) begin n_bad++; $display("FAIL rnd_bubble i=%0d got=%0b exp=%0b", i, bubble_id_ex, e_bub); end
            n_vec++; if (flush_if_id !== e_fif) begin n_bad++; $display("FAIL rnd_flush_if i=%0d got=%0b exp=%0b", i, flush_if_id, e_fif); end
            n_vec++; if (flush_ex_dm !== e_fex) begin n_bad++; $display("FAIL rnd_flush_ex i=%0d got=%0b exp=%0b", i, flush_ex_dm, e_fex); end
            e_fwd0 = 0; e_fwd1 = 0;
`ifdef HAZ_FWD_EN
            if (id_valid && !e_bub) begin
                e_fwd0 = w10 ? 1 : (w20 ? 2 : 0);
                e_fwd1 = w11 ? 1 : (w21 ? 2 : 0);
            end
`endif
            if (halt_at < 0 && id_valid && id_is_halt && !haz && !redir) halt_at = cyc;
            else if (draining && redir && since <= 2) halt_at = -1;
            if (redir) hist[hist.size() - 1].v = 0;
            hist.push_back(e_bub ? nop : cur);
            void'(hist.pop_front());
            cyc++;
            e_hlt = (halt_at >= 0) && ((cyc - halt_at) > DC);
            tick();
            if (e_hlt && (cyc - halt_at) > DC + 2) begin
                rst_n = 0;
                #1;
                n_vec++; if ({hlt, stall_if_id} !== 2'b00) begin n_bad++; $display("FAIL rnd_reset i=%0d got=%b exp=00", i, {hlt, stall_if_id}); end
                do_reset();
                hist = '{nop, nop};
                halt_at = -1; cyc = 0; e_fwd0 = 0; e_fwd1 = 0; e_hlt = 0;
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        rst_n = 0;
        test_reset();
        test_fwd_exdm();
        test_fwd_dmwb();
        test_load_use();
        test_redirect();
        test_halt();
        test_halt_squash();
        test_r0();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
